node_reducer: RTL and testbench
===============================

NODE_REDUCER -- requirements
Module: node_reducer

Interface
REQ-001 Parameter N_CELLS, default 8, number of cell result slots folded per operation; power of two, 2..64.
REQ-002 Parameter DATA_W, default 8, width of each value and context field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a fold; honoured only in IDLE.
REQ-006 selector  input  8  operation code (0 update, 1 lookUpScan, 2 lookUpFinalizer, 3 encode, 4 delete, 5 congrueUp, 6 congrueDown, 7 markAvailableCell); sampled with start.
REQ-007 cell_value  input  N_CELLS*DATA_W  per-cell result values, cell i at bits [i*DATA_W +: DATA_W].
REQ-008 cell_context  input  N_CELLS*DATA_W  per-cell contexts, same packing.
REQ-009 cell_bool  input  N_CELLS  per-cell match flags.
REQ-010 cell_done  input  N_CELLS  per-cell operation-done flags.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse, high only in DONE.
REQ-013 result_value / result_context  output  DATA_W each  folded winner.
REQ-014 result_bool  output  1  OR of all latched cell_bool.
REQ-015 result_opdone  output  1  AND of all latched cell_done.

Function
REQ-016 FSM SHALL have states IDLE, FOLD, DONE; IDLE->FOLD on start, FOLD->DONE on last index (or early exit), DONE->IDLE unconditionally.
REQ-017 On accepting start, the block SHALL latch all cell inputs and selector into an internal buffer, set acc to cell 0 and idx to 1.
REQ-018 Each FOLD cycle SHALL compute acc <= combine(left=acc, right=buf[idx]) and increment idx; leaving FOLD after idx = N_CELLS-1.
REQ-019 combine SHALL pick left when: both bools 1 and selector=1 and ctxL > ctxR; both bools 1 and selector=5 and ctxL < ctxR; otherwise (not both-true-with-selector-1/5) when boolL=1; else right. Ties go right.
REQ-020 combine SHALL set output bool = boolL OR boolR.
REQ-021 Without early exit, done SHALL rise exactly N_CELLS cycles after the cycle in which start was sampled.
REQ-022 result_* SHALL be registered, loaded only on the FOLD->DONE transition, and held until the next such transition.
REQ-023 result_bool and result_opdone SHALL be computed from the latched buffer, independent of early exit.
REQ-024 start while busy SHALL be ignored; cell input changes after acceptance SHALL not affect the result.
REQ-025 Selector values above 7 SHALL behave as selector 0.

Reset
REQ-026 reset SHALL force IDLE, clear idx, acc, buffer, and drive busy, done, result_value, result_context, result_bool, result_opdone to 0 on the next edge.
REQ-027 reset mid-FOLD or in DONE SHALL abort without a done pulse; reset has priority over start in the same cycle.

Configuration
REQ-028 Macro NODE_REDUCER_EARLY_EXIT_EN defined: in FOLD, when selector is not 1 or 5 and the new acc bool is 1, next state SHALL be DONE (result fixed thereafter).
REQ-029 Macro undefined: FOLD SHALL always visit all N_CELLS-1 indices; results identical, latency fixed.

Structure
REQ-030 Shared package node_pkg SHALL hold selector constants SEL_UPDATE..SEL_MARK_AVAIL and the FSM state enumeration.
REQ-031 Combine rule SHALL live in a combinational sub-module node_combine_unit, instantiated once.

Verification (N_CELLS=8, DATA_W=8, values 10..17 for cells 0..7, start in cycle 0)
REQ-032 selector=1, bools all 1, contexts 3,9,4,9,1,2,8,0 -> value 13, context 9, bool 1, done in cycle 8.
REQ-033 selector=5, bools all 1, contexts 5,2,7,2,6,6,6,6 -> value 13, context 2, bool 1.
REQ-034 selector=0, bools 0,0,1,0,1,0,0,0 -> value 12, context of cell 2, bool 1; done cycle 3 with EARLY_EXIT_EN, cycle 8 without.
REQ-035 selector=0, bools all 0, cell_done[4]=0 -> value 17, context of cell 7, bool 0, opdone 0.
REQ-036 reset high in cycle 4 -> cycle 5 busy 0, all outputs 0, no done; start in cycle 6 completes normally, done in cycle 14.
REQ-037 start held high through whole fold, cell inputs changed in cycle 2 -> single done, result from cycle-0 inputs, new fold begins only from IDLE.

Source files
------------

// File: rtl/node_pkg.sv
// Shared definitions for node_reducer: selector codes, FSM states and selector normalisation.
package node_pkg;

  localparam logic [7:0] SEL_UPDATE       = 8'd0;
  localparam logic [7:0] SEL_LOOKUP_SCAN  = 8'd1;
  localparam logic [7:0] SEL_LOOKUP_FINAL = 8'd2;
  localparam logic [7:0] SEL_ENCODE       = 8'd3;
  localparam logic [7:0] SEL_DELETE       = 8'd4;
  localparam logic [7:0] SEL_CONGRUE_UP   = 8'd5;
  localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd6;
  localparam logic [7:0] SEL_MARK_AVAIL   = 8'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFold = 2'd1,
    StDone = 2'd2
  } state_e;

  // Undefined opcodes fold exactly like an update.
  function automatic logic [7:0] norm_sel(input logic [7:0] sel);
    return (sel > SEL_MARK_AVAIL) ? SEL_UPDATE : sel;
  endfunction

endpackage

// File: rtl/node_reducer_if.sv
// Request/result bundle between a fold requester (master) and node_reducer (slave).
interface node_reducer_if #(
   parameter int unsigned N_CELLS = 8,
   parameter int unsigned DATA_W  = 8
);
   logic                        start;
   logic [7:0]                  selector;
   logic [N_CELLS*DATA_W-1:0]   cell_value;
   logic [N_CELLS*DATA_W-1:0]   cell_context;
   logic [N_CELLS-1:0]          cell_bool;
   logic [N_CELLS-1:0]          cell_done;
   logic                        busy;
   logic                        done;
   logic [DATA_W-1:0]           result_value;
   logic [DATA_W-1:0]           result_context;
   logic                        result_bool;
   logic                        result_opdone;

   modport master (
      output start, selector, cell_value, cell_context, cell_bool, cell_done,
      input  busy, done, result_value, result_context, result_bool, result_opdone
   );

   modport slave (
      input  start, selector, cell_value, cell_context, cell_bool, cell_done,
      output busy, done, result_value, result_context, result_bool, result_opdone
   );
endinterface

// File: rtl/node_combine_unit.sv
// Pairwise fold rule: chooses left or right (value, context) and ORs the match flags.
module node_combine_unit
   import node_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [7:0]        sel_i,
   input  logic [DATA_W-1:0] left_val_i,
   input  logic [DATA_W-1:0] left_ctx_i,
   input  logic              left_bool_i,
   input  logic [DATA_W-1:0] right_val_i,
   input  logic [DATA_W-1:0] right_ctx_i,
   input  logic              right_bool_i,
   output logic [DATA_W-1:0] out_val_o,
   output logic [DATA_W-1:0] out_ctx_o,
   output logic              out_bool_o
);
   logic both_true;
   logic pick_left;

   assign both_true = left_bool_i & right_bool_i;

   // Strict compares: equal contexts fall through to the right operand.
   always_comb begin
      pick_left = left_bool_i;
      if (both_true && (sel_i == SEL_LOOKUP_SCAN)) begin
         pick_left = (left_ctx_i > right_ctx_i);
      end else if (both_true && (sel_i == SEL_CONGRUE_UP)) begin
         pick_left = (left_ctx_i < right_ctx_i);
      end
   end

   assign out_val_o  = pick_left ? left_val_i : right_val_i;
   assign out_ctx_o  = pick_left ? left_ctx_i : right_ctx_i;
   assign out_bool_o = left_bool_i | right_bool_i;
endmodule

// File: rtl/node_reducer.sv
// Sequential fold of N_CELLS cell results into one winner.
// Optional feature: define NODE_REDUCER_EARLY_EXIT_EN to stop folding once a match is held.
module node_reducer
   import node_pkg::*;
#(
   parameter int unsigned N_CELLS = 8,
   parameter int unsigned DATA_W  = 8
) (
   input  logic          clk,
   input  logic          reset,
   node_reducer_if.slave bus
);
   localparam int unsigned IdxW = (N_CELLS > 2) ? $clog2(N_CELLS) : 1;

   state_e              state_q;
   logic [IdxW-1:0]     idx_q;
   logic [7:0]          sel_q;
   logic [DATA_W-1:0]   val_q [N_CELLS];
   logic [DATA_W-1:0]   ctx_q [N_CELLS];
   logic [N_CELLS-1:0]  bool_q;
   logic [N_CELLS-1:0]  cdone_q;
   logic [DATA_W-1:0]   acc_val_q;
   logic [DATA_W-1:0]   acc_ctx_q;
   logic                acc_bool_q;
   logic                busy_q;
   logic                done_q;
   logic [DATA_W-1:0]   res_val_q;
   logic [DATA_W-1:0]   res_ctx_q;
   logic                res_bool_q;
   logic                res_opdone_q;

   logic [DATA_W-1:0]   cmb_val;
   logic [DATA_W-1:0]   cmb_ctx;
   logic                cmb_bool;
   logic                last_idx;
   logic                early_exit;

   node_combine_unit #(
      .DATA_W (DATA_W)
   ) u_combine (
      .sel_i        (sel_q),
      .left_val_i   (acc_val_q),
      .left_ctx_i   (acc_ctx_q),
      .left_bool_i  (acc_bool_q),
      .right_val_i  (val_q[idx_q]),
      .right_ctx_i  (ctx_q[idx_q]),
      .right_bool_i (bool_q[idx_q]),
      .out_val_o    (cmb_val),
      .out_ctx_o    (cmb_ctx),
      .out_bool_o   (cmb_bool)
   );

   assign last_idx = (idx_q == IdxW'(N_CELLS - 1));

`ifdef NODE_REDUCER_EARLY_EXIT_EN
   assign early_exit = cmb_bool && (sel_q != SEL_LOOKUP_SCAN) && (sel_q != SEL_CONGRUE_UP);
`else
   assign early_exit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         sel_q        <= '0;
         bool_q       <= '0;
         cdone_q      <= '0;
         acc_val_q    <= '0;
         acc_ctx_q    <= '0;
         acc_bool_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         res_val_q    <= '0;
         res_ctx_q    <= '0;
         res_bool_q   <= 1'b0;
         res_opdone_q <= 1'b0;
         for (int i = 0; i < N_CELLS; i++) begin
            val_q[i] <= '0;
            ctx_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  for (int i = 0; i < N_CELLS; i++) begin
                     val_q[i] <= bus.cell_value[i*DATA_W +: DATA_W];
                     ctx_q[i] <= bus.cell_context[i*DATA_W +: DATA_W];
                  end
                  bool_q     <= bus.cell_bool;
                  cdone_q    <= bus.cell_done;
                  sel_q      <= norm_sel(bus.selector);
                  acc_val_q  <= bus.cell_value[0 +: DATA_W];
                  acc_ctx_q  <= bus.cell_context[0 +: DATA_W];
                  acc_bool_q <= bus.cell_bool[0];
                  idx_q      <= IdxW'(1);
                  busy_q     <= 1'b1;
                  state_q    <= StFold;
               end
            end
            StFold: begin
               acc_val_q  <= cmb_val;
               acc_ctx_q  <= cmb_ctx;
               acc_bool_q <= cmb_bool;
               idx_q      <= idx_q + IdxW'(1);
               if (last_idx || early_exit) begin
                  // Flags come from the whole buffer, so an early exit cannot skew them.
                  res_val_q    <= cmb_val;
                  res_ctx_q    <= cmb_ctx;
                  res_bool_q   <= |bool_q;
                  res_opdone_q <= &cdone_q;
                  done_q       <= 1'b1;
                  state_q      <= StDone;
               end
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.result_value   = res_val_q;
   assign bus.result_context = res_ctx_q;
   assign bus.result_bool    = res_bool_q;
   assign bus.result_opdone  = res_opdone_q;
endmodule

// File: tb/tb_node_reducer.sv
// Directed bench for node_reducer (N_CELLS=8, DATA_W=8); cycle 0 is the cycle start is sampled.
module tb_node_reducer;
   localparam int unsigned NC = 8;
   localparam int unsigned DW = 8;

`ifdef NODE_REDUCER_EARLY_EXIT_EN
   localparam int EarlyDoneCyc = 3;
`else
   localparam int EarlyDoneCyc = 8;
`endif

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   int   done_cyc;
   int   done_cnt;

   node_reducer_if #(.N_CELLS(NC), .DATA_W(DW)) bus ();

   node_reducer #(
      .N_CELLS (NC),
      .DATA_W  (DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Values 10..17 on cells 0..7; contexts given per cell.
   task automatic set_cells(input int c0, input int c1, input int c2, input int c3,
                            input int c4, input int c5, input int c6, input int c7,
                            input logic [7:0] bools, input logic [7:0] dones,
                            input logic [7:0] sel);
      int c [8];
      c = '{c0, c1, c2, c3, c4, c5, c6, c7};
      for (int i = 0; i < 8; i++) begin
         bus.cell_value[i*8 +: 8]   = 8'(10 + i);
         bus.cell_context[i*8 +: 8] = 8'(c[i]);
      end
      bus.cell_bool = bools;
      bus.cell_done = dones;
      bus.selector  = sel;
   endtask

   // Start in cycle 0, keep it high through cycle hold_until, watch cycles 1..20 for done.
   task automatic run_fold(input int hold_until, input bit scramble,
                           output int first_done, output int n_done);
      first_done = -1;
      n_done     = 0;
      bus.start  = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (c > hold_until) bus.start = 1'b0;
         if (scramble && c == 2) begin
            bus.cell_value   = {8{8'd99}};
            bus.cell_context = {8{8'd50}};
            bus.cell_bool    = 8'h00;
            bus.cell_done    = 8'h00;
            bus.selector     = 8'd0;
         end
         @(negedge clk);
         if (bus.done) begin
            n_done++;
            if (first_done < 0) first_done = c;
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.start = 1'b0;
      set_cells(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_done", 32'(bus.done), 0);
      check_eq("rst_val", 32'(bus.result_value), 0);
      check_eq("rst_ctx", 32'(bus.result_context), 0);
      check_eq("rst_bool", 32'(bus.result_bool), 0);
      check_eq("rst_opdone", 32'(bus.result_opdone), 0);

      // lookUpScan: largest context wins, tie goes right
      @(posedge clk); #1;
      set_cells(3, 9, 4, 9, 1, 2, 8, 0, 8'hFF, 8'hFF, 8'd1);
      run_fold(0, 1'b0, done_cyc, done_cnt);
      check_eq("scan_val", 32'(bus.result_value), 13);
      check_eq("scan_ctx", 32'(bus.result_context), 9);
      check_eq("scan_bool", 32'(bus.result_bool), 1);
      check_eq("scan_opdone", 32'(bus.result_opdone), 1);
      check_eq("scan_done_cyc", done_cyc, 8);
      check_eq("scan_done_cnt", done_cnt, 1);

      // congrueUp: smallest context wins, tie goes right
      set_cells(5, 2, 7, 2, 6, 6, 6, 6, 8'hFF, 8'hFF, 8'd5);
      run_fold(0, 1'b0, done_cyc, done_cnt);
      check_eq("cup_val", 32'(bus.result_value), 13);
      check_eq("cup_ctx", 32'(bus.result_context), 2);
      check_eq("cup_bool", 32'(bus.result_bool), 1);
      check_eq("cup_done_cyc", done_cyc, 8);

      // update: first true cell wins
      set_cells(20, 21, 22, 23, 24, 25, 26, 27, 8'b0001_0100, 8'hFF, 8'd0);
      run_fold(0, 1'b0, done_cyc, done_cnt);
      check_eq("upd_val", 32'(bus.result_value), 12);
      check_eq("upd_ctx", 32'(bus.result_context), 22);
      check_eq("upd_bool", 32'(bus.result_bool), 1);
      check_eq("upd_done_cyc", done_cyc, EarlyDoneCyc);

      // out-of-range selector folds as update
      set_cells(20, 21, 22, 23, 24, 25, 26, 27, 8'b0001_0100, 8'hFF, 8'd200);
      run_fold(0, 1'b0, done_cyc, done_cnt);
      check_eq("sel200_val", 32'(bus.result_value), 12);
      check_eq("sel200_done_cyc", done_cyc, EarlyDoneCyc);

      // no matches: last cell wins, one cell not done
      set_cells(20, 21, 22, 23, 24, 25, 26, 27, 8'h00, 8'b1110_1111, 8'd0);
      run_fold(0, 1'b0, done_cyc, done_cnt);
      check_eq("none_val", 32'(bus.result_value), 17);
      check_eq("none_ctx", 32'(bus.result_context), 27);
      check_eq("none_bool", 32'(bus.result_bool), 0);
      check_eq("none_opdone", 32'(bus.result_opdone), 0);
      check_eq("none_done_cyc", done_cyc, 8);

      // reset high in cycle 4 aborts; a fresh start in cycle 6 completes in cycle 14
      set_cells(3, 9, 4, 9, 1, 2, 8, 0, 8'hFF, 8'hFF, 8'd1);
      done_cyc = -1;
      done_cnt = 0;
      bus.start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         bus.start = (c == 6);
         reset     = (c == 4);
         @(negedge clk);
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == 5) begin
            check_eq("rstmid_busy", 32'(bus.busy), 0);
            check_eq("rstmid_val", 32'(bus.result_value), 0);
            check_eq("rstmid_ctx", 32'(bus.result_context), 0);
            check_eq("rstmid_bool", 32'(bus.result_bool), 0);
            check_eq("rstmid_opdone", 32'(bus.result_opdone), 0);
         end
      end
      check_eq("rstmid_done_cyc", done_cyc, 14);
      check_eq("rstmid_done_cnt", done_cnt, 1);
      check_eq("rstmid_val_after", 32'(bus.result_value), 13);

      // start held through the fold, inputs scrambled in cycle 2
      set_cells(3, 9, 4, 9, 1, 2, 8, 0, 8'hFF, 8'hFF, 8'd1);
      run_fold(7, 1'b1, done_cyc, done_cnt);
      check_eq("hold_done_cnt", done_cnt, 1);
      check_eq("hold_done_cyc", done_cyc, 8);
      check_eq("hold_val", 32'(bus.result_value), 13);
      check_eq("hold_ctx", 32'(bus.result_context), 9);
      check_eq("hold_opdone", 32'(bus.result_opdone), 1);
      check_eq("hold_busy_end", 32'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
